// File: rtl/irq_pending_arbiter.sv
// irq_pending_arbiter: latches rising-edge requests into sticky pending bits and grants the highest pending index over valid/ready.
// Ports: clk, rst (async active-low), req_in[N], clear (sync flush), out_id/out_valid/out_ready (grant stream),
//        pending[N] (status), dropped (edge on an already-pending line), mask[N] only when IRQ_MASK_EN is defined.
module irq_pending_arbiter #(
  parameter int NUM_INPUTS = 8,
  localparam int IW = $clog2(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_INPUTS-1:0] req_in,
  input  logic                  clear,
`ifdef IRQ_MASK_EN
  input  logic [NUM_INPUTS-1:0] mask,
`endif
  output logic [IW-1:0]         out_id,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUM_INPUTS-1:0] pending,
  output logic                  dropped
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q, state_d;
  logic [NUM_INPUTS-1:0] req_q, req_d, pend_q, pend_d, rise, served, elig;
  logic [IW-1:0] id_q, id_d, sel;
  logic drop_q, drop_d, armed_q, armed_d, hs;
  always_comb begin
    // Lines already high when reset releases are not treated as fresh edges.
    rise = armed_q ? req_in & ~req_q : '0;
    hs = (state_q == HOLD) && out_ready;
    served = '0;
    served[id_q] = hs;
`ifdef IRQ_MASK_EN
    elig = pend_q & ~mask;
`else
    elig = pend_q;
`endif
    sel = '0;
    for (int i = 0; i < NUM_INPUTS; i++) if (elig[i]) sel = IW'(i);
    req_d = req_in;
    armed_d = 1'b1;
    pend_d = rise | (clear ? '0 : pend_q & ~served);
    drop_d = |(rise & pend_q & ~served) && !clear;
    state_d = state_q;
    id_d = id_q;
    if (state_q == IDLE) begin
      if (!clear && |elig) begin
        state_d = HOLD;
        id_d = sel;
      end
    end else if (clear || hs) state_d = IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      req_q <= '0;
      pend_q <= '0;
      id_q <= '0;
      drop_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      pend_q <= pend_d;
      id_q <= id_d;
      drop_q <= drop_d;
      armed_q <= armed_d;
    end
  assign out_id = id_q;
  assign out_valid = (state_q == HOLD);
  assign pending = pend_q;
  assign dropped = drop_q;
endmodule

// File: tb/tb_irq_pending_arbiter.sv
// tb_irq_pending_arbiter: directed self-checking bench for irq_pending_arbiter.
module tb_irq_pending_arbiter;
  logic clk = 0, rst, clear, out_ready, out_valid, dropped;
  logic [7:0] req_in, pending;
  logic [2:0] out_id;
`ifdef IRQ_MASK_EN
  logic [7:0] mask = '0;
`endif
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  irq_pending_arbiter #(.NUM_INPUTS(8)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .clear(clear),
`ifdef IRQ_MASK_EN
    .mask(mask),
`endif
    .out_id(out_id), .out_valid(out_valid), .out_ready(out_ready),
    .pending(pending), .dropped(dropped)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic grant(input string tag, input logic [2:0] id);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_id"}, out_id, id);
  endtask
  initial begin
    rst = 0; req_in = 8'hFF; clear = 0; out_ready = 0;
    step(); step();
    chk("rst_valid", out_valid, 0);
    chk("rst_id", out_id, 0);
    chk("rst_pending", pending, 0);
    chk("rst_dropped", dropped, 0);
    rst = 1;
    step(); step();
    chk("post_rst_pending", pending, 0);
    chk("post_rst_valid", out_valid, 0);
    req_in = 0;
    step();
    // single request on line 3
    req_in = 8'h08; out_ready = 1;
    step();
    chk("single_pend", pending, 8'h08);
    chk("single_valid0", out_valid, 0);
    req_in = 0;
    step();
    grant("single", 3);
    step();
    chk("single_clr", pending, 0);
    chk("single_valid_drop", out_valid, 0);
    // priority with back-pressure
    out_ready = 0; req_in = 8'h62;
    step();
    chk("prio_pend", pending, 8'h62);
    req_in = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      grant("prio_hold", 6);
    end
    out_ready = 1;
    step();
    chk("prio_g6_pend", pending, 8'h22);
    chk("prio_gap1", out_valid, 0);
    step();
    grant("prio_g5", 5);
    step();
    chk("prio_g5_pend", pending, 8'h02);
    chk("prio_gap2", out_valid, 0);
    step();
    grant("prio_g1", 1);
    step();
    chk("prio_done", pending, 0);
    // dropped and re-arm on line 2
    out_ready = 0; req_in = 8'h04;
    step();
    chk("drop_first", dropped, 0);
    req_in = 0;
    step();
    grant("drop_hold", 2);
    req_in = 8'h04;
    step();
    chk("drop_pulse", dropped, 1);
    req_in = 0;
    step();
    chk("drop_one_cycle", dropped, 0);
    req_in = 8'h04; out_ready = 1;
    step();
    chk("rearm_no_drop", dropped, 0);
    chk("rearm_pend", pending, 8'h04);
    chk("rearm_valid", out_valid, 0);
    req_in = 0; out_ready = 0;
    step();
    grant("rearm_regrant", 2);
    out_ready = 1;
    step();
    chk("rearm_done", pending, 0);
    // clear while holding a grant
    out_ready = 0; req_in = 8'h10;
    step();
    req_in = 0;
    step();
    req_in = 8'h04;
    step();
    grant("clr_hold", 4);
    chk("clr_pend_before", pending, 8'h14);
    clear = 1; req_in = 8'h01;
    step();
    chk("clr_valid", out_valid, 0);
    chk("clr_pend", pending, 8'h01);
    clear = 0; req_in = 0;
    step();
    grant("clr_regrant", 0);
    out_ready = 1;
    step();
    chk("clr_done", pending, 0);
`ifdef IRQ_MASK_EN
    mask = 8'h80; req_in = 8'h84;
    step();
    chk("mask_pend", pending, 8'h84);
    req_in = 0;
    step();
    grant("mask_g2", 2);
    step();
    chk("mask_pend_left", pending, 8'h80);
    step();
    chk("mask_blocked", out_valid, 0);
    mask = 0;
    step();
    grant("mask_g7", 7);
    step();
    chk("mask_done", pending, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/irq_pending_arbiter.md
# irq_pending_arbiter

Captures rising-edge requests on `NUM_INPUTS` lines into a sticky pending register. Each cycle it selects the highest-index pending line, using the same priority order as the downstream priority encoder. The selected index is presented on a valid/ready output port and held until the consumer accepts it; on acceptance the served pending bit is cleared. The block sits directly upstream of the priority-encode/dispatch stage and turns bursty, pulse-style requests into a stable, back-pressured stream of line indices.

## Interface
- `NUM_INPUTS`, 8, number of request lines; must be ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_in`  in  `NUM_INPUTS`  request lines; a rising edge on bit i (0 last cycle, 1 now) sets pending bit i.
- `clear`  in  1  synchronous flush of all pending bits and of the output.
- `out_id`  out  `$clog2(NUM_INPUTS)`  index of the granted line.
- `out_valid`  out  1  `out_id` is valid.
- `out_ready`  in  1  consumer accepts `out_id` when `out_valid && out_ready`.
- `pending`  out  `NUM_INPUTS`  current pending register (registered, for status readback).
- `dropped`  out  1  one-cycle pulse: a rising edge arrived on a line already pending and not being cleared that cycle.

## Operation
- Edge detect: `req_q <= req_in` each cycle; `rise = req_in & ~req_q`.
- FSM with two states: IDLE and HOLD.
- IDLE: if `pending` (registered value) is nonzero, register `out_id` = highest set index of the eligible pending bits, set `out_valid`, go to HOLD. Otherwise stay in IDLE with `out_valid` = 0.
- HOLD: `out_id` and `out_valid` stay stable until handshake. On `out_valid && out_ready`: clear `pending[out_id]`, drop `out_valid`, go to IDLE.
- Pending update priority, per bit, highest first:
  1. `rise[i]` sets the bit.
  2. `clear` clears it.
  3. The handshake clears `pending[out_id]`.
- A rise on the line being accepted in the same cycle therefore leaves that bit set, as a new request.
- `dropped` = 1 for one cycle if any bit i has `rise[i]` with `pending[i]` = 1, and that bit is not being cleared by `clear` or by the handshake that cycle.
- `clear`: all pending bits not rising that cycle become 0. `out_valid` goes to 0 and the FSM goes to IDLE next cycle, including mid-HOLD with `out_ready` low. A simultaneous handshake is still counted as accepted by the consumer.
- A request that rises on a higher line while in HOLD does not preempt; it is considered at the next IDLE.

## Timing
- Reset values: `out_valid` = 0, `out_id` = 0, `pending` = 0, `dropped` = 0, `req_q` = 0, FSM = IDLE. Reset asserted mid-HOLD discards everything immediately and asynchronously.
- Latency: rise sampled at edge k → `pending` bit visible after k → `out_valid` = 1 after edge k+1.
- Throughput: one grant per 2 cycles maximum, because IDLE is one cycle between grants.
- `out_valid` never deasserts without a handshake, except on `clear` or reset.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `IRQ_MASK_EN` defined:
  - Adds port `mask`  in  `NUM_INPUTS`; 1 = line masked.
  - Masked lines still latch into `pending` but are excluded from selection in IDLE.
  - Masking a line while it is in HOLD does not revoke the grant.
  - IDLE advances only when `pending & ~mask` is nonzero.
- `IRQ_MASK_EN` undefined: no `mask` port; every pending bit is eligible.

## Test plan
- Reset: hold `rst` = 0 with `req_in` = 8'hFF → all outputs 0. Release, keep `req_in` = 8'hFF steady → no new rise, `pending` stays 8'h00.
- Single request: pulse `req_in[3]` at edge k with `out_ready` = 1 → `pending` = 8'h08 after k, `out_valid` = 1 and `out_id` = 3 after k+1, `pending` = 0 after k+2.
- Priority and back-pressure: rise on bits 1, 5, 6 together with `out_ready` = 0 for 5 cycles → `out_id` = 6 held stable. Then `out_ready` = 1 → grants 6, 5, 1, each 2 cycles apart.
- Dropped and re-arm: rise bit 2 twice while pending and unserved → one `dropped` pulse on the second rise. A rise on bit 2 in the cycle it is accepted → no `dropped`, and bit 2 stays pending.
- Clear mid-HOLD: `out_valid` = 1 with `out_id` = 4, `pending` = 8'h14. Assert `clear` with a rise on bit 0 → next cycle `out_valid` = 0, `pending` = 8'h01, then grant `out_id` = 0.
- Mask (`IRQ_MASK_EN`): `mask` = 8'h80, rise bits 7 and 2 → grant 2 only. Clear `mask` → grant 7.
